// File: rtl/noc_inject_arbiter.sv
// Round-robin arbiter that merges M flit streams into one registered valid/ready output.
// Also keeps a saturating count of accepted flits for each requester.
module noc_inject_arbiter #(
  parameter int WIDTH        = 32,
  parameter int N            = 16,
  parameter int N_ADDR_WIDTH = $clog2(N),
  parameter int M            = 4,
  parameter int IDX_WIDTH    = (M > 1) ? $clog2(M) : 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [M*WIDTH-1:0]     req_data_in,
  input  logic [M-1:0]           req_valid_in,
  output logic [M-1:0]           req_ready_out,
  output logic [WIDTH-1:0]       data_out,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [IDX_WIDTH-1:0]   grant_idx_out,
  output logic [M*CNT_WIDTH-1:0] grant_count_out
);

  // Flits must be wide enough to hold the {src, dst, id} header.
  if (M < 1 || M > 16 || WIDTH < 2 * N_ADDR_WIDTH + 8) begin : g_param_check
    $error("noc_inject_arbiter: illegal parameter combination");
  end

  logic [IDX_WIDTH-1:0] ptr;
  logic [IDX_WIDTH-1:0] win_idx;
  logic                 win_found;
  logic [IDX_WIDTH:0]   cand;
  logic [WIDTH-1:0]     win_data;
  logic [IDX_WIDTH-1:0] ptr_next;
  logic                 load_en;
  logic                 transfer;
  logic [CNT_WIDTH-1:0] count [M];

  assign load_en  = !valid_out || ready_in;
  assign transfer = !rst && load_en && win_found;

  // Scan from ptr upward with wrap; walking offsets high-to-low leaves the nearest valid one.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = M - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IDX_WIDTH + 1)'(k);
      cand = (cand >= (IDX_WIDTH + 1)'(M)) ? cand - (IDX_WIDTH + 1)'(M) : cand;
      win_idx   = req_valid_in[cand[IDX_WIDTH-1:0]] ? cand[IDX_WIDTH-1:0] : win_idx;
      win_found = win_found | req_valid_in[cand[IDX_WIDTH-1:0]];
    end
  end

  // Winner's flit and one-hot ready.
  always_comb begin
    win_data      = '0;
    req_ready_out = '0;
    for (int i = 0; i < M; i++) begin
      win_data         = (win_idx == IDX_WIDTH'(i)) ? req_data_in[i*WIDTH +: WIDTH] : win_data;
      req_ready_out[i] = transfer && (win_idx == IDX_WIDTH'(i));
    end
  end

  assign ptr_next = (win_idx == IDX_WIDTH'(M - 1)) ? '0 : win_idx + IDX_WIDTH'(1);

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out     <= 1'b0;
      data_out      <= '0;
      grant_idx_out <= '0;
      ptr           <= '0;
    end else if (transfer) begin
      valid_out     <= 1'b1;
      data_out      <= win_data;
      grant_idx_out <= win_idx;
      ptr           <= ptr_next;
    end else if (load_en) begin
      valid_out     <= 1'b0;
    end else begin
      valid_out     <= valid_out;
    end
  end

  // Per-requester grant counters stop at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    for (int i = 0; i < M; i++) begin
      if (rst) begin
        count[i] <= '0;
      end else if (transfer && (win_idx == IDX_WIDTH'(i)) && (count[i] != {CNT_WIDTH{1'b1}})) begin
        count[i] <= count[i] + CNT_WIDTH'(1);
      end else begin
        count[i] <= count[i];
      end
    end
  end

  for (genvar g = 0; g < M; g++) begin : g_count_out
    assign grant_count_out[g*CNT_WIDTH +: CNT_WIDTH] = count[g];
  end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Randomised bench for noc_inject_arbiter: a queue-free behavioural model checked every cycle,
// plus directed phases with hand-computed expectations.
module tb_noc_inject_arbiter;

  localparam int WIDTH = 32;
  localparam int N     = 16;
  localparam int NAW   = 4;
  localparam int M     = 4;
  localparam int IW    = 2;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [M*WIDTH-1:0] req_data_in;
  logic [M-1:0]     req_valid_in;
  logic [M-1:0]     req_ready_out;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             ready_in;
  logic [IW-1:0]    grant_idx_out;
  logic [M*CW-1:0]  grant_count_out;

  int checks = 0;
  int errors = 0;

  noc_inject_arbiter #(
    .WIDTH(WIDTH), .N(N), .N_ADDR_WIDTH(NAW), .M(M), .IDX_WIDTH(IW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_data_in(req_data_in), .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
    .grant_idx_out(grant_idx_out), .grant_count_out(grant_count_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mkflit(input int src, input int dst, input int id, input int dat);
    return {src[3:0], dst[3:0], id[7:0], dat[15:0]};
  endfunction

  function automatic logic [31:0] cnt_of(input int i);
    return 32'(grant_count_out[i*CW +: CW]);
  endfunction

  // Behavioural model state: what the output register and counters must hold.
  int             m_ptr = 0;
  int             m_idx = 0;
  bit             m_valid = 1'b0;
  logic [31:0]    m_data = 32'd0;
  int             m_cnt [M] = '{default: 0};
  localparam int  SAT = (1 << CW) - 1;

  always @(negedge clk) begin : compare
    logic [M-1:0] exp_rdy;
    int  w;
    bit  load_en;
    chk("valid_out", 32'(valid_out), 32'(m_valid));
    chk("data_out", data_out, m_data);
    chk("grant_idx_out", 32'(grant_idx_out), m_idx);
    for (int i = 0; i < M; i++) chk($sformatf("count[%0d]", i), cnt_of(i), m_cnt[i]);
    exp_rdy = '0;
    w = -1;
    load_en = !m_valid || ready_in;
    if (!rst) begin
      for (int k = 0; k < M; k++) begin
        if (w < 0 && req_valid_in[(m_ptr + k) % M]) w = (m_ptr + k) % M;
      end
      if (load_en && w >= 0) exp_rdy[w] = 1'b1;
    end
    chk("req_ready_out", 32'(req_ready_out), 32'(exp_rdy));
    if (rst) begin
      m_ptr = 0; m_idx = 0; m_valid = 1'b0; m_data = 32'd0;
      for (int i = 0; i < M; i++) m_cnt[i] = 0;
    end else if (exp_rdy != '0) begin
      m_data  = req_data_in[w*WIDTH +: WIDTH];
      m_idx   = w;
      m_valid = 1'b1;
      m_ptr   = (w + 1) % M;
      if (m_cnt[w] < SAT) m_cnt[w]++;
    end else if (load_en) begin
      m_valid = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < M; i++) req_data_in[i*WIDTH +: WIDTH] = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid_in = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin : main
    logic [31:0] held;
    rst = 1'b1;
    req_valid_in = 4'b1111;
    ready_in = 1'b1;
    rand_data();

    // Reset with every requester asking
    repeat (3) begin
      step();
      chk("rst ready", 32'(req_ready_out), 32'd0);
      chk("rst valid", 32'(valid_out), 32'd0);
      chk("rst count0", cnt_of(0), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("first ready", 32'(req_ready_out), 32'b0001);
    step();
    chk("first valid", 32'(valid_out), 32'd1);
    chk("first idx", 32'(grant_idx_out), 32'd0);

    // Single stream from requester 2
    do_reset();
    req_valid_in = 4'b0100;
    for (int id = 1; id <= 8; id++) begin
      req_data_in[2*WIDTH +: WIDTH] = mkflit(2, 5, id, id * 16'h0101);
      step();
      chk("stream valid", 32'(valid_out), 32'd1);
      chk("stream idx", 32'(grant_idx_out), 32'd2);
      chk("stream id", 32'(data_out[23:16]), 32'(id));
    end
    req_valid_in = '0;
    step();
    chk("stream drained", 32'(valid_out), 32'd0);
    chk("stream count2", cnt_of(2), 32'd8);
    chk("stream count0", cnt_of(0), 32'd0);
    chk("stream count3", cnt_of(3), 32'd0);

    // Full contention rotates 0..3
    do_reset();
    req_valid_in = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      rand_data();
      step();
      chk("rotate idx", 32'(grant_idx_out), 32'(k % 4));
    end
    req_valid_in = '0;
    step();
    for (int i = 0; i < M; i++) chk("rotate count", cnt_of(i), 32'd2);

    // Backpressure holds the register and the pointer
    req_valid_in = 4'b1111;
    step();
    chk("bp load idx", 32'(grant_idx_out), 32'd0);
    held = data_out;
    ready_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_data();
      #1;
      chk("bp ready", 32'(req_ready_out), 32'd0);
      step();
      chk("bp data", data_out, held);
      chk("bp valid", 32'(valid_out), 32'd1);
    end
    ready_in = 1'b1;
    step();
    chk("bp next idx", 32'(grant_idx_out), 32'd1);

    // Pointer skips idle requesters
    do_reset();
    req_valid_in = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("skip idx", 32'(grant_idx_out), (k % 2 == 1) ? 32'd3 : 32'd0);
    end
    req_valid_in = 4'b1000;
    repeat (2) begin
      step();
      chk("skip only3", 32'(grant_idx_out), 32'd3);
    end

    // Counter saturation on requester 1
    do_reset();
    req_valid_in = 4'b0010;
    for (int k = 1; k <= 20; k++) begin
      rand_data();
      step();
      chk("sat valid", 32'(valid_out), 32'd1);
      if (k == 15 || k == 20) chk("sat count1", cnt_of(1), 32'd15);
    end

    // Random traffic, backpressure and occasional reset
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      req_valid_in = 4'($urandom);
      ready_in = ($urandom_range(0, 3) != 0);
      rand_data();
      step();
    end

    rst = 1'b0;
    req_valid_in = '0;
    ready_in = 1'b1;
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
